// File: rtl/simon_playback_sequencer.sv
// Timed playback engine: walks the Simon pattern RAM from index 0 to len-1,
// showing each entry for ON_CYCLES cycles followed by GAP_CYCLES blank cycles.
module simon_playback_sequencer #(
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned ON_CYCLES  = 8,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] n_len,
    input  logic [3:0]       pattern_in,
    output logic [IDX_W-1:0] rd_addr,
    output logic [3:0]       led_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHOW,
        S_GAP,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [IDX_W-1:0] len_q,   len_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [3:0]       disp_q,  disp_d;
    logic [3:0]       led_q,   led_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // Next-state logic; outputs are decoded from the next state so they leave the flops clean.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    idx_d = '0;
                    if (n_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        len_d   = n_len;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                disp_d  = pattern_in;
                cnt_d   = ON_LOAD;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (cnt_q == '0) begin
                    cnt_d   = GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_q == len_q - IDX_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort cancels any active playback without a done pulse.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end

        led_d  = (state_d == S_SHOW) ? disp_d : 4'd0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rd_addr = idx_q;
    assign led_out = led_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Bench for simon_playback_sequencer: directed timing scenarios plus randomized
// playbacks, all compared against an elapsed-time reference model.
module tb_simon_playback_sequencer;

    localparam int unsigned IDX_W = 6;
    localparam int unsigned ON    = 8;
    localparam int unsigned GAP   = 4;
    localparam int unsigned CNT_W = 8;
    localparam int          P     = 1 + ON + GAP;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [IDX_W-1:0] n_len;
    logic [3:0]       pattern_in;
    logic [IDX_W-1:0] rd_addr;
    logic [3:0]       led_out;
    logic             busy;
    logic             done;

    logic [3:0] ram [64];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Reference model state: active playback, elapsed cycle index, latched length, shown value.
    bit         m_act = 1'b0;
    int         m_t   = 0;
    int         m_n   = 0;
    logic [3:0] m_val = 4'd0;

    int e_rd, e_led, e_busy, e_done;

    simon_playback_sequencer #(
        .IDX_W(IDX_W), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .n_len(n_len),
        .pattern_in(pattern_in), .rd_addr(rd_addr), .led_out(led_out),
        .busy(busy), .done(done)
    );

    // RAM read port presenting the entry addressed by rd_addr.
    assign pattern_in = ram[rd_addr];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Model: playback timeline is a function of cycles elapsed since start.
    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0;
            m_t   = 0;
        end else if (m_act) begin
            if (abort) begin
                m_act = 1'b0;
            end else begin
                if (m_n > 0 && m_t <= m_n * P && ((m_t - 1) % P) == 0)
                    m_val = ram[(m_t - 1) / P];
                m_t++;
                if (m_t > ((m_n == 0) ? 1 : m_n * P + 1)) m_act = 1'b0;
            end
        end else if (start && !abort) begin
            m_act = 1'b1;
            m_t   = 1;
            m_n   = int'(n_len);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            e_rd = 0; e_led = 0; e_busy = 0; e_done = 0;
            if (m_act) begin
                e_busy = 1;
                if (m_n == 0 || m_t == m_n * P + 1) begin
                    e_done = 1;
                    e_rd   = (m_n == 0) ? 0 : m_n - 1;
                end else begin
                    e_rd = (m_t - 1) / P;
                    if (((m_t - 1) % P) >= 1 && ((m_t - 1) % P) <= ON) e_led = int'(m_val);
                end
            end
            chk("rd_addr", 32'(rd_addr), 32'(e_rd));
            chk("led_out", 32'(led_out), 32'(e_led));
            chk("busy",    32'(busy),    32'(e_busy));
            chk("done",    32'(done),    32'(e_done));
        end
    end

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic play(output int k);
        start = 1'b1;
        k     = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int b = 0;
        while ((busy !== 1'b0 || m_act) && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (b >= budget) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int k, k2, ab_at;
        rst = 1'b1; start = 1'b0; abort = 1'b0; n_len = '0;
        for (int i = 0; i < 64; i++) ram[i] = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state, then quiet idle.
        chk("rst_rd", 32'(rd_addr), 32'd0);
        chk("rst_led", 32'(led_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        repeat (20) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Three-entry playback timing.
        ram[0] = 4'b0001; ram[1] = 4'b0100; ram[2] = 4'b1000;
        n_len = 6'd3;
        play(k);
        at(k + 1);  chk("t2_fetch_led", 32'(led_out), 32'd0);
        at(k + 2);  chk("t2_led_s0a", 32'(led_out), 32'd1);
        at(k + 9);  chk("t2_led_s0b", 32'(led_out), 32'd1);
        at(k + 10); chk("t2_gap0a", 32'(led_out), 32'd0);
        at(k + 13); chk("t2_gap0b", 32'(led_out), 32'd0);
        at(k + 15); chk("t2_led_s1a", 32'(led_out), 32'd4);
        at(k + 22); chk("t2_led_s1b", 32'(led_out), 32'd4);
        at(k + 28); chk("t2_led_s2a", 32'(led_out), 32'd8);
        at(k + 35); chk("t2_led_s2b", 32'(led_out), 32'd8);
        at(k + 39); chk("t2_done_early", 32'(done), 32'd0);
        at(k + 40); chk("t2_done", 32'(done), 32'd1);
        at(k + 41); chk("t2_busy_low", 32'(busy), 32'd0);
        wait_idle(100);

        // Zero-length playback.
        n_len = 6'd0;
        play(k);
        at(k + 1); chk("t3_done", 32'(done), 32'd1); chk("t3_led", 32'(led_out), 32'd0);
        at(k + 2); chk("t3_busy_low", 32'(busy), 32'd0); chk("t3_rd", 32'(rd_addr), 32'd0);
        wait_idle(20);

        // Abort mid-playback, then replay from index 0.
        ram[0] = 4'b0110;
        n_len = 6'd3;
        play(k);
        at(k + 16); abort = 1'b1;
        at(k + 17); abort = 1'b0;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_led", 32'(led_out), 32'd0);
        chk("t4_rd", 32'(rd_addr), 32'd0);
        repeat (3) @(negedge clk);
        play(k2);
        at(k2 + 1); chk("t4_replay_rd", 32'(rd_addr), 32'd0);
        at(k2 + 2); chk("t4_replay_led", 32'(led_out), 32'd6);
        wait_idle(100);

        // Start while busy and n_len change are ignored.
        n_len = 6'd2;
        play(k);
        at(k + 5); start = 1'b1;
        at(k + 6); start = 1'b0; n_len = 6'd5;
        at(k + 26); chk("t5_done_early", 32'(done), 32'd0);
        at(k + 27); chk("t5_done", 32'(done), 32'd1);
        at(k + 28); chk("t5_busy_low", 32'(busy), 32'd0);
        wait_idle(100);

        // Reset mid-playback; RAM change during SHOW does not reach the LEDs.
        ram[0] = 4'd3; ram[1] = 4'd5;
        n_len = 6'd3;
        play(k);
        at(k + 4);  ram[0] = 4'hC;
        at(k + 6);  chk("t6_led_held", 32'(led_out), 32'd3);
        at(k + 16); chk("t6_led_s1", 32'(led_out), 32'd5);
        at(k + 20); rst = 1'b1;
        at(k + 21); rst = 1'b0;
        chk("t6_rst_led", 32'(led_out), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_rd", 32'(rd_addr), 32'd0);
        wait_idle(50);

        // Start and abort together in IDLE: nothing happens.
        n_len = 6'd2; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("both_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);

        // Randomized playbacks with noise on start, n_len, and occasional abort.
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < 64; i++) ram[i] = 4'($urandom);
            n_len = (it == 5) ? 6'd63 : 6'($urandom_range(0, 6));
            play(k);
            ab_at = ($urandom_range(0, 3) == 0) ? k + int'($urandom_range(1, 40)) : -1;
            for (int b = 0; b < 2000 && (busy !== 1'b0 || m_act); b++) begin
                start = ($urandom_range(0, 7) == 0) && busy;
                n_len = 6'($urandom);
                abort = (cyc == ab_at);
                @(negedge clk);
            end
            start = 1'b0;
            abort = 1'b0;
            wait_idle(2000);
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
